// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster generator advanced by a pixel strobe.
// All outputs are registered from the counter values before each strobe,
// so they lag the internal counters by one strobe.
// Optional macro VGA_TIMING_PIPE_EN adds one extra strobe of delay to
// hsync, vsync and disp_en so they line up with a frame RAM of one-strobe
// read latency. The default build leaves the macro undefined.
module vga_timing #(
   parameter int unsigned H_ACTIVE   = 800,
   parameter int unsigned H_FP       = 40,
   parameter int unsigned H_SYNC     = 128,
   parameter int unsigned H_BP       = 88,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 13,
   parameter int unsigned V_SYNC     = 3,
   parameter int unsigned V_BP       = 29,
   parameter logic        H_SYNC_POL = 1'b0,
   parameter logic        V_SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pix_en,
   output logic [10:0] vga_h,
   output logic [10:0] vga_v,
   output logic        hsync,
   output logic        vsync,
   output logic        disp_en,
   output logic        line_start,
   output logic        frame_start
);

   localparam logic [10:0] H_VIS   = 11'(H_ACTIVE);
   localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_VIS   = 11'(V_ACTIVE);
   localparam logic [10:0] V_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic        hsync_nxt;
   logic        vsync_nxt;
   logic        disp_en_nxt;

   // Raster position counters: h wraps each line, v steps on h wrap.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 11'd1;
            end
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   // Decode sync and visible-area levels from the current counter values.
   always_comb begin
      hsync_nxt   = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_nxt   = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      disp_en_nxt = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   end

   // Registered position and line/frame pulses; pulses hold across stalls.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vga_h       <= '0;
         vga_v       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         vga_h       <= h_cnt;
         vga_v       <= v_cnt;
         line_start  <= (h_cnt == '0);
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

`ifdef VGA_TIMING_PIPE_EN
   logic hsync_d;
   logic vsync_d;
   logic disp_en_d;

   // Two strobe-qualified stages for the timing levels to cover RAM read latency.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hsync_d   <= ~H_SYNC_POL;
         vsync_d   <= ~V_SYNC_POL;
         disp_en_d <= 1'b0;
         hsync     <= ~H_SYNC_POL;
         vsync     <= ~V_SYNC_POL;
         disp_en   <= 1'b0;
      end else if (pix_en) begin
         hsync_d   <= hsync_nxt;
         vsync_d   <= vsync_nxt;
         disp_en_d <= disp_en_nxt;
         hsync     <= hsync_d;
         vsync     <= vsync_d;
         disp_en   <= disp_en_d;
      end
   end
`else
   // Timing levels registered alongside the position outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hsync   <= ~H_SYNC_POL;
         vsync   <= ~V_SYNC_POL;
         disp_en <= 1'b0;
      end else if (pix_en) begin
         hsync   <= hsync_nxt;
         vsync   <= vsync_nxt;
         disp_en <= disp_en_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: drives a default-parameter instance and a small,
// inverted-polarity instance with the same strobe/reset stimulus and checks
// every output after every clock against a closed-form raster model based
// on the number of strobes since reset.
module tb_vga_timing;

   // Small raster for instance B so whole frames fit in a short run.
   localparam int unsigned B_HA = 40, B_HFP = 4, B_HS = 8, B_HBP = 6;
   localparam int unsigned B_VA = 20, B_VFP = 3, B_VS = 2, B_VBP = 4;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        de;
      logic        ls;
      logic        fs;
   } vga_out_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pix_en = 1'b0;

   logic [10:0] a_h, a_v, b_h, b_v;
   logic        a_hs, a_vs, a_de, a_ls, a_fs;
   logic        b_hs, b_vs, b_de, b_ls, b_fs;

   int unsigned n_checks = 0;
   int unsigned n_err = 0;
   int unsigned strobes = 0;

   // edge tracking on instance A during the free-run phase
   logic        track = 1'b0;
   logic        prev_hs, prev_de;
   int unsigned last_fall = 0;
   int unsigned n_falls = 0;

`ifdef VGA_TIMING_PIPE_EN
   localparam int unsigned PIPE = 1;
`else
   localparam int unsigned PIPE = 0;
`endif

   always #5 clk = ~clk;

   vga_timing dut_a (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
      .vga_h(a_h), .vga_v(a_v), .hsync(a_hs), .vsync(a_vs),
      .disp_en(a_de), .line_start(a_ls), .frame_start(a_fs)
   );

   vga_timing #(
      .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
      .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
      .vga_h(b_h), .vga_v(b_v), .hsync(b_hs), .vsync(b_vs),
      .disp_en(b_de), .line_start(b_ls), .frame_start(b_fs)
   );

   // Expected outputs after k strobes since reset (k=0: reset values).
   function automatic vga_out_t model(input int unsigned k,
         input int unsigned ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
         input logic hp, vp);
      vga_out_t    r;
      int unsigned ht, vt, p, q, qh, qv;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      r.h = '0; r.v = '0; r.ls = 1'b0; r.fs = 1'b0;
      r.hs = ~hp; r.vs = ~vp; r.de = 1'b0;
      if (k >= 1) begin
         p    = (k - 1) % (ht * vt);
         r.h  = 11'(p % ht);
         r.v  = 11'(p / ht);
         r.ls = (p % ht) == 0;
         r.fs = (p == 0);
      end
      if (k >= 1 + PIPE) begin
         q    = (k - 1 - PIPE) % (ht * vt);
         qh   = q % ht;
         qv   = q / ht;
         r.hs = (qh >= ha + hfp && qh < ha + hfp + hsw) ? hp : ~hp;
         r.vs = (qv >= va + vfp && qv < va + vfp + vsw) ? vp : ~vp;
         r.de = (qh < ha) && (qv < va);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d (strobes=%0d)", tag, obs, exp, strobes);
      end
   endtask

   task automatic check_all();
      vga_out_t ea, eb;
      ea = model(strobes, 800, 40, 128, 88, 480, 13, 3, 29, 1'b0, 1'b0);
      eb = model(strobes, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1, 1'b1);
      chk("a_vga_h", a_h, ea.h);
      chk("a_vga_v", a_v, ea.v);
      chk("a_hsync", 11'(a_hs), 11'(ea.hs));
      chk("a_vsync", 11'(a_vs), 11'(ea.vs));
      chk("a_disp_en", 11'(a_de), 11'(ea.de));
      chk("a_line_start", 11'(a_ls), 11'(ea.ls));
      chk("a_frame_start", 11'(a_fs), 11'(ea.fs));
      chk("b_vga_h", b_h, eb.h);
      chk("b_vga_v", b_v, eb.v);
      chk("b_hsync", 11'(b_hs), 11'(eb.hs));
      chk("b_vsync", 11'(b_vs), 11'(eb.vs));
      chk("b_disp_en", 11'(b_de), 11'(eb.de));
      chk("b_line_start", 11'(b_ls), 11'(eb.ls));
      chk("b_frame_start", 11'(b_fs), 11'(eb.fs));
   endtask

   // One clock: apply inputs, advance the strobe count, sample at edge+1.
   task automatic step(input logic rst_n, input logic en);
      reset_n = rst_n;
      pix_en  = en;
      prev_hs = a_hs;
      prev_de = a_de;
      @(posedge clk);
      if (!rst_n) strobes = 0;
      else if (en) strobes++;
      #1;
      check_all();
      if (track) begin
         if (prev_hs && !a_hs) begin
            chk("hsync_fall_pos", a_h, 11'(840 + PIPE));
            if (n_falls > 0) chk("hsync_period", 11'(strobes - last_fall), 11'd1056);
            last_fall = strobes;
            n_falls++;
         end
         if (!prev_hs && a_hs) chk("hsync_rise_pos", a_h, 11'(968 + PIPE));
         if (prev_de && !a_de) chk("disp_en_fall_pos", a_h, 11'(800 + PIPE));
      end
   endtask

   initial begin
      // reset held for 5 strobes
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      chk("reset_hsync_high", 11'(a_hs), 11'd1);
      chk("reset_vsync_high", 11'(a_vs), 11'd1);

      // release: first strobe shows origin with both pulses
      step(1'b1, 1'b1);
      chk("first_frame_start", 11'(a_fs), 11'd1);
      chk("first_disp_en", 11'(a_de), 11'(PIPE == 0));

      // free run with edge tracking on instance A
      track = 1'b1;
      for (int i = 0; i < 3300; i++) begin
         step(1'b1, 1'b1);
         if (strobes == 801) begin
            chk("h800_pos", a_h, 11'd800);
         end
      end
      track = 1'b0;
      chk("hsync_falls_seen", 11'(n_falls), 11'd3);

      // alternating strobe: outputs hold on idle cycles
      for (int i = 0; i < 400; i++) step(1'b1, 1'(i % 2 == 0));

      // random strobe pattern
      for (int i = 0; i < 4000; i++) step(1'b1, 1'($urandom_range(0, 3) != 0));

      // mid-frame reset with strobe high, then with strobe low
      step(1'b0, 1'b1);
      for (int i = 0; i < 1500; i++) step(1'b1, 1'($urandom_range(0, 4) != 0));
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 2500; i++) step(1'b1, 1'($urandom_range(0, 7) != 0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 128, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 88, horizontal back porch in pixels; line total 1056.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 13, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 3, vertical sync width in lines.
REQ-008 Parameter V_BP, default 29, vertical back porch in lines; frame total 525.
REQ-009 Parameter H_SYNC_POL, default 0, asserted level of hsync.
REQ-010 Parameter V_SYNC_POL, default 0, asserted level of vsync.
REQ-011 Port clk, input, 1, the system clock; single clock domain.
REQ-012 Port reset_n, input, 1, reset, synchronous and active-low.
REQ-013 Port pix_en, input, 1, pixel strobe; the timing advances only on cycles where it is high.
REQ-014 Port vga_h, output, 11, horizontal pixel position, 0..1055.
REQ-015 Port vga_v, output, 11, vertical line position, 0..524.
REQ-016 Port hsync, output, 1, horizontal sync.
REQ-017 Port vsync, output, 1, vertical sync.
REQ-018 Port disp_en, output, 1, high while the position is in the visible area.
REQ-019 Port line_start, output, 1, one-strobe pulse at the start of each line.
REQ-020 Port frame_start, output, 1, one-strobe pulse at the start of each frame.

Function
REQ-021 Internal 11-bit counters h_cnt and v_cnt SHALL change only on clk edges where pix_en=1.
REQ-022 h_cnt SHALL increment by 1 and wrap from H_TOTAL-1 (1055) to 0.
REQ-023 v_cnt SHALL increment only when h_cnt wraps, and SHALL wrap from V_TOTAL-1 (524) to 0.
REQ-024 All outputs SHALL be registered and SHALL update only on pix_en cycles, from the counter values before that edge, so outputs lag the counters by one strobe.
REQ-025 vga_h and vga_v SHALL equal the registered h_cnt and v_cnt values.
REQ-026 hsync SHALL be at H_SYNC_POL when vga_h is in 840..967, and at !H_SYNC_POL otherwise.
REQ-027 vsync SHALL be at V_SYNC_POL when vga_v is in 493..495, and at !V_SYNC_POL otherwise, for the whole line.
REQ-028 disp_en SHALL be 1 if and only if vga_h<800 and vga_v<480.
REQ-029 line_start SHALL be 1 if and only if vga_h==0.
REQ-030 frame_start SHALL be 1 if and only if vga_h==0 and vga_v==0.
REQ-031 line_start and frame_start SHALL remain high across stall cycles (pix_en=0) until the next strobe.
REQ-032 With pix_en=0, every output and counter SHALL hold its value.
REQ-033 All position comparisons SHALL be derived from parameters as 11-bit unsigned values, with no truncation.

Reset
REQ-034 On a clk edge with reset_n=0, all counters and outputs SHALL reset, regardless of pix_en.
REQ-035 Reset values: h_cnt=0, v_cnt=0, vga_h=0, vga_v=0, hsync=!H_SYNC_POL, vsync=!V_SYNC_POL, disp_en=0, line_start=0, frame_start=0.
REQ-036 Reset asserted mid-frame SHALL abandon the current frame.
REQ-037 The first strobe after release SHALL present vga_h=0, vga_v=0, disp_en=1, line_start=1, frame_start=1.

Configuration
REQ-038 Macro VGA_TIMING_PIPE_EN, when defined, SHALL add one extra pix_en-qualified register stage to hsync, vsync and disp_en only, to match the one-strobe read latency of the frame RAM.
REQ-039 With VGA_TIMING_PIPE_EN defined, vga_h, vga_v, line_start and frame_start SHALL be unchanged.
REQ-040 With VGA_TIMING_PIPE_EN defined, the extra stage SHALL reset to the REQ-035 values.
REQ-041 Without VGA_TIMING_PIPE_EN, hsync, vsync and disp_en SHALL be aligned with vga_h and vga_v as in REQ-026 to REQ-028.

Verification
REQ-042 Reset test: hold reset_n=0 for 5 strobes -> vga_h=0, vga_v=0, hsync=1, vsync=1, disp_en=0, both pulses 0.
REQ-043 Release test: release reset, then apply 1 strobe -> (0,0), disp_en=1, frame_start=1; after 800 strobes -> vga_h=800, disp_en=0.
REQ-044 Hsync test: free-run with pix_en=1 -> hsync falls when vga_h=840, rises when vga_h=968, and its period is 1056 strobes.
REQ-045 Frame test: free-run -> vsync is low for lines 493..495; after (524,1055) the next strobe gives (0,0) with frame_start=1; frame period is 554400 strobes.
REQ-046 Stall and mid-frame reset test: pix_en alternating 1/0 -> outputs hold on 0-cycles; reset_n=0 at (300,200) -> REQ-035 values on the next edge.
REQ-047 Pipe test: with VGA_TIMING_PIPE_EN defined, hsync falls when vga_h=841 and disp_en falls when vga_h=801.
